mem_tester: RTL and testbench
=============================

MEM_TESTER -- requirements
Module: mem_tester

Interface
REQ-001 Parameter ACC_CYC, default 2: cycles that control is held at WRITE or READ per word access; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock shared with the memory core.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a test run; sampled only in IDLE.
REQ-005 baseAddr  input  16  first word address of the test region; latched at start.
REQ-006 length  input  16  number of words to test; latched at start.
REQ-007 seed  input  16  pattern seed; latched at start.
REQ-008 dataRead  input  16  read data returned by the memory core.
REQ-009 control  output  2  core command: 00 IDLE, 01 WRITE, 10 READ; 11 is never driven.
REQ-010 addr  output  16  word address presented to the core.
REQ-011 dataWrite  output  16  write data presented to the core.
REQ-012 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-013 done  output  1  one-cycle pulse on entry to DONE.
REQ-014 pass  output  1  high in DONE when errCount==0; low otherwise.
REQ-015 errCount  output  16  mismatch count, saturating at 16'hFFFF.
REQ-016 failAddr  output  16  address of the first mismatch in the run; 0 if none.

Function
REQ-017 States SHALL be IDLE, WR, WGAP, RD, RCHK, DONE; all outputs SHALL be registered.
REQ-018 Pattern for word i SHALL be expected(i) = (baseAddr+i) XOR seed, where the addition is mod 2^16 and the address wraps from FFFF to 0000.
REQ-019 IDLE with start=1 and length!=0: latch inputs, clear errCount/failAddr/pass, set i=0, enter WR next cycle.
REQ-020 IDLE with start=1 and length==0: enter DONE next cycle with pass=1 and no memory access.
REQ-021 WR: control=01, addr=baseAddr+i, dataWrite=expected(i), held for exactly ACC_CYC cycles, then go to WGAP.
REQ-022 WGAP: control=00 for one cycle; increment i; if i reaches length, reset i=0 and enter RD; otherwise enter WR.
REQ-023 RD: control=10, addr=baseAddr+i, held for ACC_CYC cycles, then go to RCHK.
REQ-024 RCHK: control=00; compare dataRead with expected(i) during this cycle; on mismatch increment errCount (saturating); if this is the first mismatch, load failAddr=addr.
REQ-025 RCHK: increment i; if i reaches length, enter DONE; otherwise enter RD.
REQ-026 Each word costs ACC_CYC+1 cycles per phase; total run = 2*length*(ACC_CYC+1) cycles from the first WR cycle to DONE entry.
REQ-027 DONE: control=00, done pulses for one cycle, pass valid; next cycle return to IDLE; errCount/failAddr/pass hold until the next accepted start.
REQ-028 start while busy SHALL be ignored; latched inputs SHALL NOT change during a run.
REQ-029 dataWrite SHALL be 0 outside WR.
REQ-030 addr SHALL hold its last value in IDLE and DONE.

Reset
REQ-031 rst low SHALL immediately force state=IDLE, control=00, addr=0, dataWrite=0, busy=0, done=0, pass=0, errCount=0, failAddr=0, i=0, and clear the phase counter.
REQ-032 Reset asserted mid-run SHALL abort the run with no done pulse; after rst deassertion a new start is required.

Structure
REQ-033 Shared package SHALL hold the control encodings IDLE/WRITE/READ (00/01/10), shared with the memory core, and the state encoding.
REQ-034 One natural sub-module: mem_pattern_gen, which produces address and expected data from base, seed and i.

Verification
REQ-035 Clean run: base=0010, length=4, seed=A5A5, ideal memory model -> 4 writes of 0010^A5A5..0013^A5A5, done after 24 cycles, pass=1, errCount=0.
REQ-036 Stuck bit: model forces dataRead[3]=0, base=0000, length=16, seed=0000 -> errCount=8, failAddr=0008, pass=0.
REQ-037 Wrap: base=FFFE, length=4 -> addr sequence FFFE, FFFF, 0000, 0001 in both phases; pass=1.
REQ-038 length=0 with start -> done one cycle later, pass=1, control stays 00 throughout.
REQ-039 rst pulsed low during the RD phase -> all outputs return to reset values immediately, no done pulse; a following start=1 runs cleanly.
REQ-040 start asserted during a run plus ACC_CYC=1 build -> the extra start is ignored, and each access holds control for exactly 1 cycle followed by a 1-cycle gap.

Source files
------------

// File: rtl/mem_tester_pkg.sv
// rtl/mem_tester_pkg.sv - shared encodings for the memory tester and the memory core
// Core command codes, tester state encoding and the test pattern function.
package mem_tester_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_WRITE = 2'b01,
    CTRL_READ  = 2'b10
  } ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WGAP = 3'd2,
    S_RD   = 3'd3,
    S_RCHK = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // The data written to a word is its own address scrambled by the seed.
  function automatic logic [15:0] pattern_word(input logic [15:0] word_addr,
                                               input logic [15:0] seed);
    return word_addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_tester_if.sv
// rtl/mem_tester_if.sv - run control and memory core bus of the memory tester
// master is the tester side; slave is the requester plus memory core side.
interface mem_tester_if;
  logic        start;
  logic [15:0] baseAddr;
  logic [15:0] length;
  logic [15:0] seed;
  logic [15:0] dataRead;
  logic [1:0]  control;
  logic [15:0] addr;
  logic [15:0] dataWrite;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] errCount;
  logic [15:0] failAddr;

  modport master (
    input  start, baseAddr, length, seed, dataRead,
    output control, addr, dataWrite, busy, done, pass, errCount, failAddr
  );

  modport slave (
    output start, baseAddr, length, seed, dataRead,
    input  control, addr, dataWrite, busy, done, pass, errCount, failAddr
  );
endinterface

// File: rtl/mem_pattern_gen.sv
// rtl/mem_pattern_gen.sv - address and expected data for word index idx
// Address wraps modulo 2^16 from the base.
module mem_pattern_gen
  import mem_tester_pkg::*;
(
  input  logic [15:0] base,
  input  logic [15:0] seed,
  input  logic [15:0] idx,
  output logic [15:0] word_addr,
  output logic [15:0] word_data
);

  assign word_addr = base + idx;
  assign word_data = pattern_word(word_addr, seed);

endmodule

// File: rtl/mem_tester.sv
// rtl/mem_tester.sv - write-then-read-back memory tester with error count and first fail address
// Every output is a register loaded from the next-state decode, so it lines up with the state.
module mem_tester
  import mem_tester_pkg::*;
#(
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_tester_if.master  bus
);

  localparam logic [3:0] LAST_CYC = 4'(ACC_CYC - 1);

  state_e      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] idx, idx_nx;
  logic [15:0] base_q, base_nx;
  logic [15:0] len_q, len_nx;
  logic [15:0] seed_q, seed_nx;
  logic [15:0] exp_q, exp_nx;

  ctrl_e       control_q, control_nx;
  logic [15:0] addr_q, addr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [15:0] err_q, err_nx;
  logic [15:0] fail_q, fail_nx;
  logic        busy_q, busy_nx;
  logic        done_q, done_nx;
  logic        pass_q, pass_nx;

  logic [15:0] gen_addr, gen_data;
  logic        last_word;
  logic        mismatch;

  assign last_word = (idx + 16'd1) == len_q;
  assign mismatch  = bus.dataRead != exp_q;

  // Fed with next-cycle values so the registered addr/data match the state being entered.
  mem_pattern_gen u_pattern (
    .base      (base_nx),
    .seed      (seed_nx),
    .idx       (idx_nx),
    .word_addr (gen_addr),
    .word_data (gen_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      idx       <= 16'h0;
      base_q    <= 16'h0;
      len_q     <= 16'h0;
      seed_q    <= 16'h0;
      exp_q     <= 16'h0;
      control_q <= CTRL_IDLE;
      addr_q    <= 16'h0;
      wdata_q   <= 16'h0;
      err_q     <= 16'h0;
      fail_q    <= 16'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      base_q    <= base_nx;
      len_q     <= len_nx;
      seed_q    <= seed_nx;
      exp_q     <= exp_nx;
      control_q <= control_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      err_q     <= err_nx;
      fail_q    <= fail_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      pass_q    <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    base_nx  = base_q;
    len_nx   = len_q;
    seed_nx  = seed_q;
    err_nx   = err_q;
    fail_nx  = fail_q;
    pass_nx  = pass_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          base_nx  = bus.baseAddr;
          len_nx   = bus.length;
          seed_nx  = bus.seed;
          err_nx   = 16'h0;
          fail_nx  = 16'h0;
          idx_nx   = 16'h0;
          cnt_nx   = 4'd0;
          pass_nx  = bus.length == 16'h0;
          state_nx = (bus.length == 16'h0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        if (cnt == LAST_CYC) begin
          cnt_nx   = 4'd0;
          state_nx = S_WGAP;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_WGAP: begin
        if (last_word) begin
          idx_nx   = 16'h0;
          state_nx = S_RD;
        end else begin
          idx_nx   = idx + 16'd1;
          state_nx = S_WR;
        end
      end
      S_RD: begin
        if (cnt == LAST_CYC) begin
          cnt_nx   = 4'd0;
          state_nx = S_RCHK;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_RCHK: begin
        // A saturated count never returns to zero, so err_q==0 marks the first miss.
        if (mismatch) begin
          if (err_q != ERR_MAX) err_nx = err_q + 16'd1;
          if (err_q == 16'h0)   fail_nx = addr_q;
        end
        if (last_word) begin
          idx_nx   = 16'h0;
          pass_nx  = err_nx == 16'h0;
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx + 16'd1;
          state_nx = S_RD;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    control_nx = CTRL_IDLE;
    addr_nx    = addr_q;
    wdata_nx   = 16'h0;
    exp_nx     = exp_q;
    if (state_nx == S_WR) begin
      control_nx = CTRL_WRITE;
      addr_nx    = gen_addr;
      wdata_nx   = gen_data;
      exp_nx     = gen_data;
    end else if (state_nx == S_RD) begin
      control_nx = CTRL_READ;
      addr_nx    = gen_addr;
      exp_nx     = gen_data;
    end
    busy_nx = (state_nx == S_WR) || (state_nx == S_WGAP) ||
              (state_nx == S_RD) || (state_nx == S_RCHK);
    done_nx = state_nx == S_DONE;
  end

  assign bus.control   = control_q;
  assign bus.addr      = addr_q;
  assign bus.dataWrite = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.errCount  = err_q;
  assign bus.failAddr  = fail_q;

endmodule

// File: tb/tb_mem_tester.sv
// tb/tb_mem_tester.sv - scoreboard bench for mem_tester (ACC_CYC=2 and ACC_CYC=1 builds)
// Expected write words and read addresses are queued at start and popped as accesses appear.
module tb_mem_tester;
  import mem_tester_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_tester_if b0 ();
  mem_tester_if b1 ();

  mem_tester #(.ACC_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  mem_tester #(.ACC_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  bit stuck = 1'b0;

  always @(posedge clk) if (b0.control == CTRL_WRITE) mem0[b0.addr] <= b0.dataWrite;
  always @(posedge clk) if (b1.control == CTRL_WRITE) mem1[b1.addr] <= b1.dataWrite;
  assign b0.dataRead = stuck ? (mem0[b0.addr] & 16'hFFF7) : mem0[b0.addr];
  assign b1.dataRead = mem1[b1.addr];

  bit          sel = 1'b0;
  logic [1:0]  m_control;
  logic [15:0] m_addr, m_dataWrite, m_errCount, m_failAddr;
  logic        m_busy, m_done, m_pass;
  assign m_control   = sel ? b1.control   : b0.control;
  assign m_addr      = sel ? b1.addr      : b0.addr;
  assign m_dataWrite = sel ? b1.dataWrite : b0.dataWrite;
  assign m_busy      = sel ? b1.busy      : b0.busy;
  assign m_done      = sel ? b1.done      : b0.done;
  assign m_pass      = sel ? b1.pass      : b0.pass;
  assign m_errCount  = sel ? b1.errCount  : b0.errCount;
  assign m_failAddr  = sel ? b1.failAddr  : b0.failAddr;

  logic [31:0] wq[$];
  logic [15:0] rq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive_start(input bit s, input logic st, input logic [15:0] ba,
                             input logic [15:0] ln, input logic [15:0] sd);
    if (s) begin
      b1.start = st; b1.baseAddr = ba; b1.length = ln; b1.seed = sd;
    end else begin
      b0.start = st; b0.baseAddr = ba; b0.length = ln; b0.seed = sd;
    end
  endtask

  // Plays one run; checks every access against the scoreboard, hold length and gap length.
  task automatic run_test(input bit s, input logic [15:0] base, input logic [15:0] len,
                          input logic [15:0] sd, input int extra_at,
                          output int cycles, output int nacc);
    int          acc, n, runlen, gap;
    logic [1:0]  prev;
    bit          got_done;
    logic [15:0] a, r;
    logic [31:0] w;
    sel = s;
    acc = s ? 1 : 2;
    wq.delete();
    rq.delete();
    for (int k = 0; k < int'(len); k++) begin
      a = base + 16'(k);
      wq.push_back({a, a ^ sd});
      rq.push_back(a);
    end
    @(negedge clk);
    drive_start(s, 1'b1, base, len, sd);
    @(negedge clk);
    drive_start(s, 1'b0, base, len, sd);
    n = 1; prev = 2'b00; runlen = 0; gap = 0; got_done = 1'b0; nacc = 0;
    while (!got_done && n <= 4000) begin
      if (n == extra_at) drive_start(s, 1'b1, base ^ 16'h5A5A, len + 16'd3, ~sd);
      else if (n == extra_at + 1) drive_start(s, 1'b0, base, len, sd);
      if (n == 1) begin
        n_checks++;
        if (m_busy !== (len != 16'h0))
          $display("FAIL busy_after_start: got %b want %b", m_busy, len != 16'h0);
        if (m_busy !== (len != 16'h0)) n_fail++;
      end
      n_checks++;
      if (m_control === 2'b11) begin
        n_fail++; $display("FAIL control_11: control driven 11 at cycle %0d", n);
      end
      if (m_control !== 2'b00) begin
        if (prev === 2'b00) begin
          nacc++;
          if (nacc > 1) begin
            n_checks++;
            if (gap != 1) begin
              n_fail++; $display("FAIL gap_len: got %0d want 1 at cycle %0d", gap, n);
            end
          end
          n_checks++;
          if (m_control === CTRL_WRITE) begin
            if (wq.size() == 0) begin
              n_fail++; $display("FAIL write_extra: unexpected write addr %h", m_addr);
            end else begin
              w = wq.pop_front();
              if ({m_addr, m_dataWrite} !== w) begin
                n_fail++;
                $display("FAIL write_word: got addr %h data %h want addr %h data %h",
                         m_addr, m_dataWrite, w[31:16], w[15:0]);
              end
            end
          end else begin
            if (rq.size() == 0) begin
              n_fail++; $display("FAIL read_extra: unexpected read addr %h", m_addr);
            end else begin
              r = rq.pop_front();
              if (m_addr !== r) begin
                n_fail++; $display("FAIL read_addr: got %h want %h", m_addr, r);
              end
            end
          end
          runlen = 0;
        end
        runlen++;
        gap = 0;
      end else begin
        if (prev !== 2'b00) begin
          n_checks++;
          if (runlen != acc) begin
            n_fail++; $display("FAIL hold_len: got %0d want %0d", runlen, acc);
          end
        end
        n_checks++;
        if (m_dataWrite !== 16'h0) begin
          n_fail++; $display("FAIL dataWrite_idle: got %h want 0000", m_dataWrite);
        end
        gap++;
      end
      prev = m_control;
      if (m_done === 1'b1) got_done = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    drive_start(s, 1'b0, base, len, sd);
    cycles = n - 1;
    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL done_timeout: no done within 4000 cycles");
    end
    n_checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      n_fail++; $display("FAIL leftover: writes %0d reads %0d not seen", wq.size(), rq.size());
    end
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_in_done: got %b want 0", m_busy);
    end
  endtask

  task automatic test_reset();
    drive_start(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    drive_start(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (b0.control !== 2'b00) begin n_fail++; $display("FAIL rst_control: got %b want 00", b0.control); end
    n_checks++;
    if (b0.addr !== 16'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", b0.addr); end
    n_checks++;
    if (b0.dataWrite !== 16'h0) begin n_fail++; $display("FAIL rst_dataWrite: got %h want 0000", b0.dataWrite); end
    n_checks++;
    if ({b0.busy, b0.done, b0.pass} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags: busy/done/pass got %b want 000", {b0.busy, b0.done, b0.pass});
    end
    n_checks++;
    if ({b0.errCount, b0.failAddr} !== 32'h0) begin
      n_fail++; $display("FAIL rst_err: err %h fail %h want 0", b0.errCount, b0.failAddr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (b0.control !== 2'b00 || b0.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst: control %b busy %b want 00/0", b0.control, b0.busy);
    end
  endtask

  task automatic test_clean();
    int cyc, nacc;
    run_test(1'b0, 16'h0010, 16'd4, 16'hA5A5, -1, cyc, nacc);
    n_checks++;
    if (cyc != 24) begin n_fail++; $display("FAIL clean_cycles: got %0d want 24", cyc); end
    n_checks++;
    if (m_pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %b want 1", m_pass); end
    n_checks++;
    if (m_errCount !== 16'h0 || m_failAddr !== 16'h0) begin
      n_fail++; $display("FAIL clean_err: err %h fail %h want 0", m_errCount, m_failAddr);
    end
    n_checks++;
    if (nacc != 8) begin n_fail++; $display("FAIL clean_accesses: got %0d want 8", nacc); end
    @(negedge clk);
    n_checks++;
    if (m_done !== 1'b0 || m_pass !== 1'b1 || m_addr !== 16'h0013) begin
      n_fail++; $display("FAIL clean_hold: done %b pass %b addr %h want 0 1 0013", m_done, m_pass, m_addr);
    end
  endtask

  task automatic test_stuck_bit();
    int cyc, nacc;
    stuck = 1'b1;
    run_test(1'b0, 16'h0000, 16'd16, 16'h0000, -1, cyc, nacc);
    n_checks++;
    if (m_errCount !== 16'd8) begin n_fail++; $display("FAIL stuck_err: got %0d want 8", m_errCount); end
    n_checks++;
    if (m_failAddr !== 16'h0008) begin n_fail++; $display("FAIL stuck_failaddr: got %h want 0008", m_failAddr); end
    n_checks++;
    if (m_pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %b want 0", m_pass); end
    n_checks++;
    if (cyc != 96) begin n_fail++; $display("FAIL stuck_cycles: got %0d want 96", cyc); end
    stuck = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_errCount !== 16'd8) begin n_fail++; $display("FAIL stuck_hold: got %0d want 8", m_errCount); end
  endtask

  task automatic test_wrap();
    int cyc, nacc;
    run_test(1'b0, 16'hFFFE, 16'd4, 16'h1234, -1, cyc, nacc);
    n_checks++;
    if (m_pass !== 1'b1 || m_errCount !== 16'h0) begin
      n_fail++; $display("FAIL wrap_pass: pass %b err %h want 1 0000", m_pass, m_errCount);
    end
    n_checks++;
    if (nacc != 8) begin n_fail++; $display("FAIL wrap_accesses: got %0d want 8", nacc); end
  endtask

  task automatic test_len_zero();
    int cyc, nacc;
    run_test(1'b0, 16'h0040, 16'd0, 16'hFFFF, -1, cyc, nacc);
    n_checks++;
    if (cyc != 0) begin n_fail++; $display("FAIL len0_latency: got %0d extra cycles want 0", cyc); end
    n_checks++;
    if (nacc != 0) begin n_fail++; $display("FAIL len0_access: got %0d accesses want 0", nacc); end
    n_checks++;
    if (m_pass !== 1'b1 || m_errCount !== 16'h0) begin
      n_fail++; $display("FAIL len0_pass: pass %b err %h want 1 0000", m_pass, m_errCount);
    end
  endtask

  task automatic test_reset_mid_run();
    int  cyc, nacc;
    bit  found, bad;
    sel = 1'b0;
    @(negedge clk);
    drive_start(1'b0, 1'b1, 16'h0100, 16'd8, 16'h0F0F);
    @(negedge clk);
    drive_start(1'b0, 1'b0, 16'h0100, 16'd8, 16'h0F0F);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (b0.control === CTRL_READ) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrst_reach_rd: RD phase not seen within 200 cycles"); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({b0.control, b0.addr, b0.dataWrite, b0.busy, b0.done, b0.pass, b0.errCount, b0.failAddr} !== 69'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: control %b addr %h dw %h busy %b done %b pass %b err %h fail %h want all 0",
               b0.control, b0.addr, b0.dataWrite, b0.busy, b0.done, b0.pass, b0.errCount, b0.failAddr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (b0.done !== 1'b0 || b0.control !== 2'b00 || b0.busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL midrst_quiet: activity or done after reset without start"); end
    run_test(1'b0, 16'h0100, 16'd8, 16'h0F0F, -1, cyc, nacc);
    n_checks++;
    if (cyc != 48 || m_pass !== 1'b1 || m_errCount !== 16'h0) begin
      n_fail++; $display("FAIL midrst_rerun: cycles %0d pass %b err %h want 48 1 0000", cyc, m_pass, m_errCount);
    end
  endtask

  task automatic test_start_ignored_acc1();
    int cyc, nacc;
    run_test(1'b1, 16'h0200, 16'd3, 16'h00FF, 2, cyc, nacc);
    n_checks++;
    if (cyc != 12) begin n_fail++; $display("FAIL acc1_cycles: got %0d want 12", cyc); end
    n_checks++;
    if (nacc != 6 || m_pass !== 1'b1) begin
      n_fail++; $display("FAIL acc1_run: accesses %0d pass %b want 6 1", nacc, m_pass);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nacc;
    run_test(1'b1, 16'h0300, 16'd5, 16'hC3C3, -1, cyc, nacc);
    n_checks++;
    if (cyc != 20 || m_pass !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: cycles %0d pass %b want 20 1", cyc, m_pass);
    end
    run_test(1'b1, 16'h0302, 16'd2, 16'h0001, -1, cyc, nacc);
    n_checks++;
    if (cyc != 8 || m_pass !== 1'b1 || m_errCount !== 16'h0) begin
      n_fail++; $display("FAIL b2b_second: cycles %0d pass %b err %h want 8 1 0000", cyc, m_pass, m_errCount);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck_bit();
    test_wrap();
    test_len_zero();
    test_reset_mid_run();
    test_start_ignored_acc1();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
